// File: rtl/neo_mem_sequencer.sv
// NEO sequencer: streams samples from a single-port memory, computes
// psi[n] = x[n]^2 - x[n-1]*x[n+1], and writes the scaled, saturated result back.
module neo_mem_sequencer #(
  parameter int N        = 8,
  parameter int M        = 16,
  parameter int NUM      = 8,
  parameter int RES_BASE = 8,
  parameter int SHIFT    = 7
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf,
  output logic [$clog2(M):0]        raddr,
  input  logic signed [N-1:0]       rdata,
  output logic [$clog2(M):0]        waddr,
  output logic signed [N-1:0]       wdata
);

  localparam int AW = $clog2(M) + 1;
  localparam int PW = 2 * N + 1;
  localparam logic [AW-1:0]        LAST   = AW'(NUM - 1);
  localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (N - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-(1 << (N - 1)));

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_CAP, CALC, WR, DONE} state_t;

  state_t state, state_nxt;
  logic [AW-1:0] idx;
  logic signed [N-1:0] xm1, x0, xp1;

  logic signed [PW-1:0] xm1_e, x0_e, xp1_e, sq, cr, p, q;
  logic signed [N-1:0]  sat;
  logic                 clamp;
  logic [AW-1:0]        res_addr;

  always_ff @(posedge Clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_ISSUE;
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = RD_CAP;
      // the first two reads only prime the window
      RD_CAP:   state_nxt = (idx < AW'(2)) ? RD_ISSUE : CALC;
      CALC:     state_nxt = WR;
      WR:       state_nxt = (idx == LAST) ? DONE : RD_ISSUE;
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Sign-extend to full product width so the difference never wraps.
  always_comb begin
    xm1_e    = {{(N + 1){xm1[N-1]}}, xm1};
    x0_e     = {{(N + 1){x0[N-1]}},  x0};
    xp1_e    = {{(N + 1){xp1[N-1]}}, xp1};
    sq       = x0_e * x0_e;
    cr       = xm1_e * xp1_e;
    p        = sq - cr;
    q        = p >>> SHIFT;
    clamp    = (q > SAT_HI) || (q < SAT_LO);
    sat      = (q > SAT_HI) ? SAT_HI[N-1:0] :
               (q < SAT_LO) ? SAT_LO[N-1:0] : q[N-1:0];
    res_addr = AW'(RES_BASE) + idx - AW'(1);
  end

  // waddr/wdata are nonzero only during WR; zero/zero parks the write port.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      idx   <= '0;
      ovf   <= 1'b0;
      raddr <= '0;
      waddr <= '0;
      wdata <= '0;
      xm1   <= '0;
      x0    <= '0;
      xp1   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ovf <= 1'b0;
          idx <= '0;
        end
        RD_ISSUE: raddr <= idx;
        RD_CAP: begin
          xm1 <= x0;
          x0  <= xp1;
          xp1 <= rdata;
          if (idx < AW'(2)) idx <= idx + AW'(1);
        end
        CALC: begin
          waddr <= res_addr;
          wdata <= sat;
          if (clamp) ovf <= 1'b1;
        end
        WR: begin
          waddr <= '0;
          wdata <= '0;
          if (idx != LAST) idx <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_mem_sequencer.sv
// Bench for neo_mem_sequencer: two instances (NUM=4/SHIFT=0 and NUM=8/SHIFT=7)
// each backed by a behavioural memory, checked against an arithmetic NEO model.
module tb_neo_mem_sequencer;
  localparam int N  = 8;
  localparam int M  = 16;
  localparam int AW = $clog2(M) + 1;
  localparam int RB = 8;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, ovf0, busy1, done1, ovf1;
  logic [AW-1:0] raddr0, waddr0, raddr1, waddr1;
  logic signed [N-1:0] rdata0 = '0, rdata1 = '0;
  logic signed [N-1:0] wdata0, wdata1;

  logic signed [N-1:0] mem0 [32];
  logic signed [N-1:0] mem1 [32];
  logic signed [N-1:0] img0 [32];
  logic signed [N-1:0] img1 [32];
  logic ld0 = 1'b0, ld1 = 1'b0;

  int wa0[$], wd0[$], wa1[$], wd1[$];
  int dn0 = 0, dn1 = 0;
  int checks = 0, errors = 0;
  int exp_a[$], exp_d[$];
  int exp_ovf;

  neo_mem_sequencer #(.N(N), .M(M), .NUM(4), .RES_BASE(RB), .SHIFT(0)) u0 (
    .Clk(Clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .ovf(ovf0),
    .raddr(raddr0), .rdata(rdata0), .waddr(waddr0), .wdata(wdata0));

  neo_mem_sequencer #(.N(N), .M(M), .NUM(8), .RES_BASE(RB), .SHIFT(7)) u1 (
    .Clk(Clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .ovf(ovf1),
    .raddr(raddr1), .rdata(rdata1), .waddr(waddr1), .wdata(wdata1));

  always #5 Clk = ~Clk;

  // Memories: registered read, write unless the port is parked at zero/zero.
  always @(posedge Clk) begin
    rdata0 <= mem0[raddr0];
    rdata1 <= mem1[raddr1];
    if (ld0) mem0 <= img0;
    else if (!(waddr0 == '0 && wdata0 == '0)) begin
      mem0[waddr0] <= wdata0;
      wa0.push_back(int'(waddr0));
      wd0.push_back(int'(wdata0));
    end
    if (ld1) mem1 <= img1;
    else if (!(waddr1 == '0 && wdata1 == '0)) begin
      mem1[waddr1] <= wdata1;
      wa1.push_back(int'(waddr1));
      wd1.push_back(int'(wdata1));
    end
    if (done0) dn0 <= dn0 + 1;
    if (done1) dn1 <= dn1 + 1;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int gbusy(input int d);  return d ? int'(busy1) : int'(busy0); endfunction
  function automatic int gdone(input int d);  return d ? int'(done1) : int'(done0); endfunction
  function automatic int govf(input int d);   return d ? int'(ovf1)  : int'(ovf0);  endfunction
  function automatic int gwaddr(input int d); return d ? int'(waddr1) : int'(waddr0); endfunction
  function automatic int gwdata(input int d); return d ? int'(wdata1) : int'(wdata0); endfunction
  function automatic int graddr(input int d); return d ? int'(raddr1) : int'(raddr0); endfunction

  task automatic set_start(input int d, input logic v);
    if (d != 0) start1 = v;
    else        start0 = v;
  endtask

  task automatic load(input int d);
    @(negedge Clk);
    if (d != 0) ld1 = 1'b1;
    else        ld0 = 1'b1;
    @(negedge Clk);
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  // Reference: psi from the sample list, shifted and clamped, one write per n.
  task automatic model(input int d, input int num, input int shift);
    int x[$];
    int p, q;
    exp_a.delete();
    exp_d.delete();
    exp_ovf = 0;
    for (int i = 0; i < num; i++) x.push_back(d != 0 ? int'(mem1[i]) : int'(mem0[i]));
    for (int n = 1; n <= num - 2; n++) begin
      p = x[n] * x[n] - x[n-1] * x[n+1];
      q = p >>> shift;
      if (q > 127)       begin q = 127;  exp_ovf = 1; end
      else if (q < -128) begin q = -128; exp_ovf = 1; end
      exp_a.push_back(RB + n);
      exp_d.push_back(q);
    end
  endtask

  task automatic do_run(input int d, input int num, input int shift, input int poke, input string tag);
    int cnt, d_before, nw;
    model(d, num, shift);
    if (d != 0) begin wa1.delete(); wd1.delete(); end
    else        begin wa0.delete(); wd0.delete(); end
    d_before = d != 0 ? dn1 : dn0;
    @(negedge Clk); set_start(d, 1'b1);
    @(negedge Clk); set_start(d, 1'b0);
    chk({tag, ".busy_run"}, gbusy(d), 1);
    cnt = 0;
    while (gdone(d) == 0 && cnt < 400) begin
      @(negedge Clk);
      cnt++;
      set_start(d, cnt == poke);
    end
    set_start(d, 1'b0);
    chk({tag, ".done_edge"}, cnt, 6 + 5 * (num - 2));
    chk({tag, ".ovf"}, govf(d), exp_ovf);
    chk({tag, ".busy_done"}, gbusy(d), 0);
    repeat (8) @(negedge Clk);
    chk({tag, ".idle_waddr"}, gwaddr(d), 0);
    chk({tag, ".idle_wdata"}, gwdata(d), 0);
    chk({tag, ".done_pulses"}, (d != 0 ? dn1 : dn0) - d_before, 1);
    chk({tag, ".ovf_hold"}, govf(d), exp_ovf);
    nw = d != 0 ? wa1.size() : wa0.size();
    chk({tag, ".nwrites"}, nw, exp_a.size());
    for (int i = 0; i < nw && i < exp_a.size(); i++) begin
      chk({tag, ".waddr"}, d != 0 ? wa1[i] : wa0[i], exp_a[i]);
      chk({tag, ".wdata"}, d != 0 ? wd1[i] : wd0[i], exp_d[i]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin img0[i] = '0; img1[i] = '0; end
    ld0 = 1'b1; ld1 = 1'b1;
    repeat (3) @(negedge Clk);
    ld0 = 1'b0; ld1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst.busy",  gbusy(d),  0);
      chk("rst.done",  gdone(d),  0);
      chk("rst.ovf",   govf(d),   0);
      chk("rst.raddr", graddr(d), 0);
      chk("rst.waddr", gwaddr(d), 0);
      chk("rst.wdata", gwdata(d), 0);
    end
    reset = 1'b1;
    @(negedge Clk);

    // basic ramp
    img0[0] = 8'sd10; img0[1] = 8'sd20; img0[2] = 8'sd30; img0[3] = 8'sd40;
    load(0);
    do_run(0, 4, 0, 0, "t1");
    chk("t1.mem9",  int'(mem0[9]),  100);
    chk("t1.mem10", int'(mem0[10]), 100);

    // positive clamp, then a zero result that must still land
    for (int i = 0; i < 32; i++) img0[i] = mem0[i];
    img0[0] = 8'sd0; img0[1] = 8'sd127; img0[2] = 8'sd0; img0[3] = 8'sd0; img0[10] = 8'sd55;
    load(0);
    do_run(0, 4, 0, 0, "t2a");
    chk("t2a.mem9",  int'(mem0[9]),  127);
    chk("t2a.mem10", int'(mem0[10]), 0);

    // negative clamp
    img0[0] = 8'sd100; img0[1] = 8'sd0; img0[2] = 8'sd100; img0[3] = 8'sd0;
    load(0);
    do_run(0, 4, 0, 0, "t2b");
    chk("t2b.mem9", int'(mem0[9]), -128);
    chk("t2b.ovf",  int'(ovf0), 1);

    // shifted result stays in range
    img1[1] = 8'sd127;
    load(1);
    do_run(1, 8, 7, 0, "t3");
    chk("t3.mem9", int'(mem1[9]), 126);

    // reset mid-run, sampled at edge 8
    wa0.delete();
    @(negedge Clk); start0 = 1'b1;
    @(negedge Clk); start0 = 1'b0;
    repeat (7) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    chk("t4.busy",  int'(busy0), 0);
    chk("t4.done",  int'(done0), 0);
    chk("t4.ovf",   int'(ovf0),  0);
    chk("t4.raddr", int'(raddr0), 0);
    chk("t4.waddr", int'(waddr0), 0);
    chk("t4.wdata", int'(wdata0), 0);
    repeat (3) @(negedge Clk);
    reset = 1'b1;
    repeat (12) @(negedge Clk);
    chk("t4.no_write", wa0.size(), 0);
    do_run(0, 4, 0, 0, "t4_fresh");

    // start pulsed while busy must be ignored
    do_run(0, 4, 0, 5, "t5");

    // randomized samples on both instances
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) img0[i] = N'($urandom_range(0, 255));
      load(0);
      do_run(0, 4, 0, (r % 2 == 1) ? 7 : 0, "rnd0");
      for (int i = 0; i < 8; i++) img1[i] = N'($urandom_range(0, 255));
      load(1);
      do_run(1, 8, 7, (r % 2 == 0) ? 12 : 0, "rnd1");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
